// File: rtl/lcd_stream_source_pkg.sv
// lcd_stream_source_pkg: shared types and helpers for the LCD pixel stream source.
// Revision 1.0
`default_nettype none

package lcd_stream_source_pkg;

    localparam int CNT_BITS = 8;

    typedef enum logic [1:0] {
        ST_DROP  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // FIFO entry record for the default RGB565 pixel; the top builds the
    // same {sof, data} layout for its configured color width.
    localparam int RGB565_BITS = 16;
    typedef struct packed {
        logic                   sof;
        logic [RGB565_BITS-1:0] data;
    } entry_565_t;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_stream_fifo.sv
// lcd_stream_fifo: synchronous first-word-fall-through FIFO, power-of-two depth.
// Revision 1.0
`default_nettype none

module lcd_stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk_spi,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_spi) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_spi) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_stream_source.sv
// lcd_stream_source: aligns an upstream pixel stream to the SPI display's x/y scan.
// Revision 1.0
`default_nettype none

module lcd_stream_source
    import lcd_stream_source_pkg::*;
#(
    parameter int                      C_COLOR_BITS = 16,
    parameter int                      C_X_SIZE     = 240,
    parameter int                      C_Y_SIZE     = 240,
    parameter int                      C_X_BITS     = $clog2(C_X_SIZE),
    parameter int                      C_Y_BITS     = $clog2(C_Y_SIZE),
    parameter int                      C_FIFO_DEPTH = 16,
    parameter logic [C_COLOR_BITS-1:0] C_FILL       = '0
) (
    input  logic                    clk_spi,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [C_COLOR_BITS-1:0] s_data,
    input  logic                    s_sof,
    input  logic [C_X_BITS-1:0]     x,
    input  logic [C_Y_BITS-1:0]     y,
    input  logic                    next_pixel,
    output logic [C_COLOR_BITS-1:0] color,
    output logic                    aligned,
    output logic [CNT_BITS-1:0]     underrun_cnt,
    output logic [CNT_BITS-1:0]     resync_cnt
);

    typedef struct packed {
        logic                    sof;
        logic [C_COLOR_BITS-1:0] data;
    } entry_t;

    state_t state;
    entry_t wdata;
    entry_t head;
    logic   full;
    logic   empty;
    logic   pop;
    logic   prime;
    logic   check_pending;
    logic   at_origin;
    logic   origin_event;
    logic   check_ok;

    assign wdata        = '{sof: s_sof, data: s_data};
    assign s_ready      = !full;
    assign aligned      = (state == ST_RUN);
    assign at_origin    = (x == '0) && (y == '0);
    // Before the first next_pixel the display core is still initialising.
    assign origin_event = at_origin && (next_pixel || prime);
    assign check_ok     = (head.sof == at_origin);

    lcd_stream_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_spi (clk_spi),
        .reset   (reset),
        .push    (s_valid),
        .wdata   (wdata),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    // A failing check wins over a coincident next_pixel: no pop on resync.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_DROP: pop = !empty && !head.sof;
            ST_RUN:  pop = next_pixel && !empty && !(check_pending && !check_ok);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_spi) begin
        if (reset) begin
            state         <= ST_DROP;
            prime         <= 1'b1;
            check_pending <= 1'b0;
            color         <= C_FILL;
            underrun_cnt  <= '0;
            resync_cnt    <= '0;
        end else begin
            if (next_pixel) begin
                prime <= 1'b0;
            end
            color <= (state == ST_RUN && !empty && !check_pending) ? head.data : C_FILL;

            case (state)
                ST_DROP: begin
                    if (!empty && head.sof) begin
                        state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (origin_event) begin
                        state         <= ST_RUN;
                        check_pending <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (check_pending && !empty && !check_ok) begin
                        resync_cnt    <= sat_inc(resync_cnt);
                        state         <= ST_DROP;
                        check_pending <= 1'b0;
                    end else if (next_pixel && empty) begin
                        underrun_cnt  <= sat_inc(underrun_cnt);
                        resync_cnt    <= sat_inc(resync_cnt);
                        state         <= ST_DROP;
                        check_pending <= 1'b0;
                    end else if (next_pixel) begin
                        check_pending <= 1'b1;
                    end else if (check_pending && !empty) begin
                        check_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_DROP;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_stream_source.sv
// tb_lcd_stream_source: directed stimulus with a queue-based scoreboard on the outputs.
// Revision 1.0
`default_nettype none

module tb_lcd_stream_source;

    localparam logic [15:0] FILL = 16'h0841;
    localparam logic [15:0] A0 = 16'hA000, A1 = 16'hA111, A2 = 16'hA222, A3 = 16'hA333;
    localparam logic [15:0] B0 = 16'hB000, B1 = 16'hB111, C0 = 16'hC000;
    localparam logic [15:0] D0 = 16'hD000, G0 = 16'h6000, F0 = 16'hF000;

    logic        clk_spi = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_sof;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        next_pixel;
    logic [15:0] color;
    logic        aligned;
    logic [7:0]  underrun_cnt;
    logic [7:0]  resync_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] color;
        logic        aligned;
        logic [7:0]  und;
        logic [7:0]  res;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk_spi = ~clk_spi;

    lcd_stream_source #(
        .C_COLOR_BITS (16),
        .C_X_SIZE     (240),
        .C_Y_SIZE     (240),
        .C_FIFO_DEPTH (16),
        .C_FILL       (FILL)
    ) dut (
        .clk_spi      (clk_spi),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_sof        (s_sof),
        .x            (x),
        .y            (y),
        .next_pixel   (next_pixel),
        .color        (color),
        .aligned      (aligned),
        .underrun_cnt (underrun_cnt),
        .resync_cnt   (resync_cnt)
    );

    // Monitor: compares every queued expectation at the falling edge.
    always @(negedge clk_spi) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (color !== mon_e.color || aligned !== mon_e.aligned || underrun_cnt !== mon_e.und ||
                resync_cnt !== mon_e.res || s_ready !== mon_e.ready) begin
                failures++;
                $display("FAIL %s: got color=%h aligned=%b und=%0d res=%0d ready=%b, want color=%h aligned=%b und=%0d res=%0d ready=%b",
                         mon_e.name, color, aligned, underrun_cnt, resync_cnt, s_ready,
                         mon_e.color, mon_e.aligned, mon_e.und, mon_e.res, mon_e.ready);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_spi);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic [15:0] c, input logic al,
                              input logic [7:0] u, input logic [7:0] r, input logic rdy);
        exp_t e;
        e.name = nm; e.color = c; e.aligned = al; e.und = u; e.res = r; e.ready = rdy;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic pulse(input int px, input int py);
        x = 8'(px);
        y = 8'(py);
        next_pixel = 1'b1;
        tick();
        next_pixel = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int k2;
        reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        x = '0; y = '0; next_pixel = 1'b0;
        tick(3);
        expect_out("reset", FILL, 1'b0, 8'd0, 8'd0, 1'b1);
        tick();
        reset = 1'b0;

        // First frame: sof pixel, origin while still priming.
        s_valid = 1'b1; s_sof = 1'b1; s_data = A0; tick();
        s_sof = 1'b0; s_data = A1; tick();
        expect_out("align_state", FILL, 1'b0, 8'd0, 8'd0, 1'b1);
        s_data = A2; tick();
        expect_out("run_entry", FILL, 1'b1, 8'd0, 8'd0, 1'b1);
        s_data = A3; tick();
        s_valid = 1'b0;
        expect_out("first_pixel", A0, 1'b1, 8'd0, 8'd0, 1'b1);

        tick(16);
        pulse(1, 0);
        expect_out("np1_hold", A0, 1'b1, 8'd0, 8'd0, 1'b1);
        tick();
        expect_out("np1_check", FILL, 1'b1, 8'd0, 8'd0, 1'b1);
        tick();
        expect_out("np1_a1", A1, 1'b1, 8'd0, 8'd0, 1'b1);
        tick(14);
        pulse(2, 0);
        tick(2);
        expect_out("np2_a2", A2, 1'b1, 8'd0, 8'd0, 1'b1);

        // Drain and underrun.
        tick(14);
        pulse(3, 0);
        tick(15);
        pulse(4, 0);
        tick(15);
        expect_out("drained", FILL, 1'b1, 8'd0, 8'd0, 1'b1);
        pulse(5, 0);
        expect_out("underrun", FILL, 1'b0, 8'd1, 8'd1, 1'b1);

        s_valid = 1'b1; s_sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = D0 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        tick(4);
        expect_out("drop_discard", FILL, 1'b0, 8'd1, 8'd1, 1'b1);

        s_valid = 1'b1; s_sof = 1'b1; s_data = B0; tick();
        s_sof = 1'b0; s_data = B1; tick();
        s_valid = 1'b0;
        tick(14);
        pulse(0, 0);
        expect_out("realign", FILL, 1'b1, 8'd1, 8'd1, 1'b1);
        tick();
        expect_out("realign_b0", B0, 1'b1, 8'd1, 8'd1, 1'b1);

        // Misplaced sof mid-line forces a resync.
        s_valid = 1'b1; s_sof = 1'b1; s_data = C0; tick();
        s_valid = 1'b0; s_sof = 1'b0;
        tick(14);
        pulse(1, 0);
        tick(2);
        expect_out("b1", B1, 1'b1, 8'd1, 8'd1, 1'b1);
        tick(14);
        pulse(5, 0);
        expect_out("mismatch_pop", B1, 1'b1, 8'd1, 8'd1, 1'b1);
        tick();
        expect_out("sof_mismatch", FILL, 1'b0, 8'd1, 8'd2, 1'b1);
        tick();
        expect_out("to_align", FILL, 1'b0, 8'd1, 8'd2, 1'b1);
        tick(14);
        pulse(3, 0);
        tick(2);
        expect_out("no_origin", FILL, 1'b0, 8'd1, 8'd2, 1'b1);
        tick(14);
        pulse(0, 0);
        tick();
        expect_out("resync_c0", C0, 1'b1, 8'd1, 8'd2, 1'b1);

        // Reset with the FIFO partly filled.
        s_valid = 1'b1; s_sof = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_data = G0 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        tick(2);
        reset = 1'b1;
        tick();
        expect_out("reset_mid", FILL, 1'b0, 8'd0, 8'd0, 1'b1);
        reset = 1'b0; x = '0; y = '0;
        tick(6);
        expect_out("reset_empty", FILL, 1'b0, 8'd0, 8'd0, 1'b1);

        // Back-pressure: fill to depth, then free one slot.
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (!s_ready) break;
            s_valid = 1'b1;
            s_sof = (k == 0);
            s_data = F0 + 16'(k);
            k++;
            tick();
        end
        check_val("fill_count", k, 16);
        expect_out("full", F0, 1'b1, 8'd0, 8'd0, 1'b0);
        k2 = 0;
        for (int j = 0; j < 10; j++) begin
            next_pixel = (j == 0);
            if (j == 0) x = 8'd1;
            if (s_ready) begin
                s_sof = 1'b0;
                s_data = F0 + 16'd16;
                k2++;
            end
            tick();
        end
        next_pixel = 1'b0;
        s_valid = 1'b0;
        check_val("one_more", k2, 1);
        expect_out("after_release", F0 + 16'd1, 1'b1, 8'd0, 8'd0, 1'b0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
